// File: rtl/bit_expand_compress_pkg.sv
// Shared definitions for the bit expand/compress datapath.
// Contents:
//   MODE_EXPAND / MODE_COMPRESS - operation select values for the mode port
//   state_e                     - sequencer states IDLE, RUN, FINISH
//   clog2                       - ceiling log2, used to size counters and indices
package bit_expand_pkg;

  localparam logic MODE_EXPAND   = 1'b0;
  localparam logic MODE_COMPRESS = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  // Smallest r with 2**r >= value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bit_expand_lane.sv
// Combinational LANES-wide prefix counter for the expand/compress datapath.
// Each lane is one index bit. Lane j is the j-th bit from the top, so it sits
// at lane_bits_i[LANES-1-j].
// Ports:
//   lane_bits_i - index bits taken this cycle, top lane in the MSB
//   count_i     - ones seen before this cycle (saturated)
//   pos_o[j]    - short-vector bit position for lane j (N_SHORT-1-(c+s_j))
//   sel_o[j]    - lane j is a one that still fits inside the short vector
//   count_o     - updated ones count, saturated at N_SHORT+1
module bit_expand_lane
  import bit_expand_pkg::*;
#(
  parameter int N_SHORT = 256,
  parameter int LANES   = 1,
  parameter int CW      = 9,
  parameter int PW      = 8
) (
  input  logic [LANES-1:0]         lane_bits_i,
  input  logic [CW-1:0]            count_i,
  output logic [LANES-1:0][PW-1:0] pos_o,
  output logic [LANES-1:0]         sel_o,
  output logic [CW-1:0]            count_o
);

  // Headroom so that c + LANES never wraps before it is saturated.
  localparam int AW = CW + clog2(LANES + 1) + 1;
  localparam logic [AW-1:0] SHORT_A = AW'(N_SHORT);
  localparam logic [AW-1:0] SAT_A   = AW'(N_SHORT + 1);

  logic [AW-1:0] acc;

  // Walk the lanes from the top, handing each one-bit the next free slot.
  always_comb begin
    acc   = AW'(count_i);
    pos_o = '0;
    sel_o = '0;
    for (int j = 0; j < LANES; j++) begin
      if (lane_bits_i[LANES-1-j]) begin
        if (acc < SHORT_A) begin
          sel_o[j] = 1'b1;
          pos_o[j] = PW'(SHORT_A - AW'(1) - acc);
        end
        acc = acc + AW'(1);
      end
    end
    count_o = (acc > SAT_A) ? CW'(SAT_A) : CW'(acc);
  end

endmodule

// File: rtl/bit_expand_compress.sv
// Scatter/gather engine between an N_SHORT-bit short vector and an N_LONG-bit
// long vector, steered by an N_LONG-bit index mask (MSB first, LANES bits per
// cycle).
// Ports:
//   clk, resetn              - clock, asynchronous active-low reset
//   load_chunk, chunk_in     - load the next CHUNK_W slice of the short buffer
//   index_valid, index       - latch a new selection mask
//   mode, long_in, start     - start an expand (0) or compress (1) operation
//   busy, done               - sequencing status; done is sticky
//   expanded_out             - expand result
//   compressed_out           - compress result
//   weight_err               - mask weight differs from N_SHORT
module bit_expand_compress
  import bit_expand_pkg::*;
#(
  parameter int N_LONG  = 450,
  parameter int N_SHORT = 256,
  parameter int CHUNK_W = 128,
  parameter int LANES   = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load_chunk,
  input  logic [CHUNK_W-1:0] chunk_in,
  input  logic               index_valid,
  input  logic [N_LONG-1:0]  index,
  input  logic               mode,
  input  logic [N_LONG-1:0]  long_in,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [N_LONG-1:0]  expanded_out,
  output logic [N_SHORT-1:0] compressed_out,
  output logic               weight_err
);

  localparam int NCH  = N_SHORT / CHUNK_W;
  localparam int PTRW = (NCH > 1) ? clog2(NCH) : 1;
  localparam int NCYC = N_LONG / LANES;
  localparam int CYW  = (NCYC > 1) ? clog2(NCYC) : 1;
  localparam int CW   = clog2(N_SHORT + 2);
  localparam int PW   = (N_SHORT > 1) ? clog2(N_SHORT) : 1;
  localparam logic [CW-1:0]   SHORT_C  = CW'(N_SHORT);
  localparam logic [CYW-1:0]  LAST_CYC = CYW'(NCYC - 1);
  localparam logic [PTRW-1:0] LAST_PTR = PTRW'(NCH - 1);

  state_e               state_q, state_d;
  logic [N_SHORT-1:0]   shortBuf_q;
  logic [PTRW-1:0]      chunkPtr_q;
  logic [N_LONG-1:0]    index_q;
  logic [N_LONG-1:0]    workIdx_q;
  logic [N_LONG-1:0]    workLong_q;
  logic                 mode_q;
  logic [CW-1:0]        onesCnt_q;
  logic [CYW-1:0]       cycCnt_q;
  logic                 done_q;
  logic                 weightErr_q;
  logic [N_LONG-1:0]    expanded_q;
  logic [N_SHORT-1:0]   compressed_q;

  logic                   startAccept;
  logic [LANES-1:0]       laneBits;
  logic [LANES-1:0][PW-1:0] lanePos;
  logic [LANES-1:0]       laneSel;
  logic [CW-1:0]          laneCount;
  logic [LANES-1:0]       expandBits;
  logic [N_SHORT-1:0]     compressedNext;

  // index_valid takes priority over a simultaneous start.
  assign startAccept = start && !index_valid;
  assign laneBits    = workIdx_q[N_LONG-1 -: LANES];

  bit_expand_lane #(
    .N_SHORT(N_SHORT),
    .LANES  (LANES),
    .CW     (CW),
    .PW     (PW)
  ) u_lane (
    .lane_bits_i(laneBits),
    .count_i    (onesCnt_q),
    .pos_o      (lanePos),
    .sel_o      (laneSel),
    .count_o    (laneCount)
  );

  // Per-lane expand bits (top lane lands in the MSB) and compress scatter.
  always_comb begin
    expandBits     = '0;
    compressedNext = compressed_q;
    for (int j = 0; j < LANES; j++) begin
      if (laneSel[j]) begin
        expandBits[LANES-1-j]   = shortBuf_q[lanePos[j]];
        compressedNext[lanePos[j]] = workLong_q[N_LONG-1-j];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startAccept) state_d = RUN;
      RUN:     if (cycCnt_q == LAST_CYC) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: buffer loading and mask latch happen only while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shortBuf_q   <= '0;
      chunkPtr_q   <= '0;
      index_q      <= '0;
      workIdx_q    <= '0;
      workLong_q   <= '0;
      mode_q       <= MODE_EXPAND;
      onesCnt_q    <= '0;
      cycCnt_q     <= '0;
      done_q       <= 1'b0;
      weightErr_q  <= 1'b0;
      expanded_q   <= '0;
      compressed_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_chunk) begin
            for (int k = 0; k < NCH; k++) begin
              if (chunkPtr_q == PTRW'(k)) shortBuf_q[N_SHORT-1-k*CHUNK_W -: CHUNK_W] <= chunk_in;
            end
            chunkPtr_q <= (chunkPtr_q == LAST_PTR) ? '0 : chunkPtr_q + PTRW'(1);
          end
          if (index_valid) begin
            index_q     <= index;
            done_q      <= 1'b0;
            weightErr_q <= 1'b0;
            chunkPtr_q  <= '0;
          end else if (start) begin
            workIdx_q   <= index_q;
            workLong_q  <= long_in;
            mode_q      <= mode;
            onesCnt_q   <= '0;
            cycCnt_q    <= '0;
            done_q      <= 1'b0;
            weightErr_q <= 1'b0;
            if (mode == MODE_EXPAND) expanded_q <= '0;
            else                     compressed_q <= '0;
          end
        end
        RUN: begin
          workIdx_q  <= workIdx_q << LANES;
          workLong_q <= workLong_q << LANES;
          onesCnt_q  <= laneCount;
          cycCnt_q   <= cycCnt_q + CYW'(1);
          if (mode_q == MODE_EXPAND) expanded_q <= {expanded_q[N_LONG-LANES-1:0], expandBits};
          else                       compressed_q <= compressedNext;
          // Overweight is known as soon as the count saturates.
          if (laneCount > SHORT_C) weightErr_q <= 1'b1;
        end
        FINISH: begin
          done_q      <= 1'b1;
          weightErr_q <= (onesCnt_q != SHORT_C);
        end
        default: ;
      endcase
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign expanded_out   = expanded_q;
  assign compressed_out = compressed_q;
  assign weight_err     = weightErr_q;

endmodule

// File: tb/tb_bit_expand_compress.sv
// Self-checking bench for bit_expand_compress. Two instances (LANES=1 and
// LANES=3) share the same stimulus and are compared against a bit-serial
// reference model of the select/scatter rules.
module tb_bit_expand_compress;

  localparam int NL  = 450;
  localparam int NS  = 256;
  localparam int CWD = 128;
  localparam int NCH = NS / CWD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetn, load_chunk, index_valid, mode, start;
  logic [CWD-1:0] chunk_in;
  logic [NL-1:0]  index, long_in;
  logic           busy1, done1, werr1, busy3, done3, werr3;
  logic [NL-1:0]  exp1, exp3;
  logic [NS-1:0]  comp1, comp3;

  bit_expand_compress #(.N_LONG(NL), .N_SHORT(NS), .CHUNK_W(CWD), .LANES(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .load_chunk(load_chunk), .chunk_in(chunk_in),
    .index_valid(index_valid), .index(index), .mode(mode), .long_in(long_in),
    .start(start), .busy(busy1), .done(done1), .expanded_out(exp1),
    .compressed_out(comp1), .weight_err(werr1)
  );

  bit_expand_compress #(.N_LONG(NL), .N_SHORT(NS), .CHUNK_W(CWD), .LANES(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .load_chunk(load_chunk), .chunk_in(chunk_in),
    .index_valid(index_valid), .index(index), .mode(mode), .long_in(long_in),
    .start(start), .busy(busy3), .done(done3), .expanded_out(exp3),
    .compressed_out(comp3), .weight_err(werr3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NS-1:0] mBuf;
  int            mPtr;
  logic [NL-1:0] mIdx;
  logic [NL-1:0] mExp;
  logic [NS-1:0] mComp;

  task automatic checkOutput(input string tag, input logic [NL-1:0] actual, input logic [NL-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [NL-1:0] randVec();
    logic [NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i] = 1'($urandom_range(1, 0));
    return v;
  endfunction

  function automatic logic [NL-1:0] randIndex(input int w);
    logic [NL-1:0] v;
    int cnt;
    int p;
    v = '0;
    cnt = 0;
    while (cnt < w) begin
      p = $urandom_range(NL - 1, 0);
      if (!v[p]) begin
        v[p] = 1'b1;
        cnt++;
      end
    end
    return v;
  endfunction

  task automatic checkAllZero(input string when);
    checkOutput({when, "_busy1"}, NL'(busy1), NL'(0));
    checkOutput({when, "_done1"}, NL'(done1), NL'(0));
    checkOutput({when, "_werr1"}, NL'(werr1), NL'(0));
    checkOutput({when, "_exp1"}, exp1, NL'(0));
    checkOutput({when, "_comp1"}, NL'(comp1), NL'(0));
    checkOutput({when, "_busy3"}, NL'(busy3), NL'(0));
    checkOutput({when, "_done3"}, NL'(done3), NL'(0));
    checkOutput({when, "_werr3"}, NL'(werr3), NL'(0));
    checkOutput({when, "_exp3"}, exp3, NL'(0));
    checkOutput({when, "_comp3"}, NL'(comp3), NL'(0));
  endtask

  task automatic loadChunk(input logic [CWD-1:0] d);
    @(negedge clk);
    load_chunk = 1'b1;
    chunk_in   = d;
    mBuf[NS-1-mPtr*CWD -: CWD] = d;
    mPtr = (mPtr + 1) % NCH;
    @(negedge clk);
    load_chunk = 1'b0;
  endtask

  task automatic setIndex(input logic [NL-1:0] idx, input logic withStart);
    @(negedge clk);
    index_valid = 1'b1;
    index       = idx;
    start       = withStart;
    mIdx = idx;
    mPtr = 0;
    @(negedge clk);
    index_valid = 1'b0;
    start       = 1'b0;
    checkOutput("iv_busy1", NL'(busy1), NL'(0));
    checkOutput("iv_busy3", NL'(busy3), NL'(0));
    checkOutput("iv_done1", NL'(done1), NL'(0));
    checkOutput("iv_werr3", NL'(werr3), NL'(0));
  endtask

  // One operation on both instances. disturbAt: cycle at which ignored
  // inputs are thrown at the busy DUTs. abortAt: cycle at which reset hits.
  task automatic applyStimulus(input logic runMode, input logic [NL-1:0] runLong,
                               input int disturbAt, input int abortAt);
    logic [NL-1:0] e;
    logic [NS-1:0] c;
    int ones, overK;
    int expDone1, expDone3, expErr1, expErr3;
    int fDone1, fDone3, fErr1, fErr3;
    e = mExp;
    c = mComp;
    if (runMode == 1'b0) e = '0;
    else                 c = '0;
    ones  = 0;
    overK = -1;
    for (int i = NL - 1; i >= 0; i--) begin
      if (mIdx[i]) begin
        if (ones < NS) begin
          if (runMode == 1'b0) e[i] = mBuf[NS-1-ones];
          else                 c[NS-1-ones] = runLong[i];
        end
        if (ones == NS) overK = NL - 1 - i;
        ones++;
      end
    end
    expDone1 = NL + 2;
    expDone3 = NL / 3 + 2;
    if (overK >= 0) begin
      expErr1 = overK + 2;
      expErr3 = overK / 3 + 2;
    end else if (ones != NS) begin
      expErr1 = expDone1;
      expErr3 = expDone3;
    end else begin
      expErr1 = 0;
      expErr3 = 0;
    end
    fDone1 = 0; fDone3 = 0; fErr1 = 0; fErr3 = 0;

    @(negedge clk);
    mode    = runMode;
    long_in = runLong;
    start   = 1'b1;
    for (int n = 1; n <= NL + 20; n++) begin
      @(negedge clk);
      start = 1'b0; load_chunk = 1'b0; index_valid = 1'b0;
      if (n == 1) begin
        checkOutput("run_busy1", NL'(busy1), NL'(1));
        checkOutput("run_busy3", NL'(busy3), NL'(1));
        checkOutput("run_done_clr", NL'(done1), NL'(0));
      end
      if (abortAt != 0 && n == abortAt) begin
        resetn = 1'b0;
        #1;
        checkAllZero("abort");
        mBuf = '0; mPtr = 0; mIdx = '0; mExp = '0; mComp = '0;
        @(negedge clk);
        resetn = 1'b1;
        return;
      end
      if (n == disturbAt) begin
        start       = 1'b1;
        load_chunk  = 1'b1;
        chunk_in    = CWD'(randVec());
        index_valid = 1'b1;
        index       = randVec();
        mode        = ~runMode;
        long_in     = randVec();
      end
      if (done1 && fDone1 == 0) fDone1 = n;
      if (done3 && fDone3 == 0) fDone3 = n;
      if (werr1 && fErr1 == 0) fErr1 = n;
      if (werr3 && fErr3 == 0) fErr3 = n;
      if (fDone1 != 0 && fDone3 != 0) break;
    end
    mExp  = e;
    mComp = c;
    checkOutput("done1_cycle", NL'(fDone1), NL'(expDone1));
    checkOutput("done3_cycle", NL'(fDone3), NL'(expDone3));
    checkOutput("werr1_cycle", NL'(fErr1), NL'(expErr1));
    checkOutput("werr3_cycle", NL'(fErr3), NL'(expErr3));
    checkOutput("exp1", exp1, e);
    checkOutput("exp3", exp3, e);
    checkOutput("comp1", NL'(comp1), NL'(c));
    checkOutput("comp3", NL'(comp3), NL'(c));
    checkOutput("done3_sticky", NL'(done3), NL'(1));
    checkOutput("busy1_end", NL'(busy1), NL'(0));
  endtask

  initial begin
    logic [NL-1:0]  idx, lng;
    logic [CWD-1:0] x0, x1;
    resetn = 1'b0; load_chunk = 1'b0; chunk_in = '0; index_valid = 1'b0;
    index = '0; mode = 1'b0; long_in = '0; start = 1'b0;
    mBuf = '0; mPtr = 0; mIdx = '0; mExp = '0; mComp = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    resetn = 1'b1;

    $display("[TB] expand, top 256 index bits");
    loadChunk({64{2'b10}});
    loadChunk({64{2'b01}});
    setIndex({{256{1'b1}}, {194{1'b0}}}, 1'b0);
    applyStimulus(1'b0, '0, 0, 0);
    checkOutput("top256_direct", exp1, {{64{2'b10}}, {64{2'b01}}, 194'b0});

    $display("[TB] expand, alternate index bits");
    for (int i = 0; i < NL; i++) idx[i] = (i % 2 == 1);
    setIndex(idx, 1'b0);
    applyStimulus(1'b0, '0, 0, 0);

    $display("[TB] compress, all-ones index");
    lng = randVec();
    setIndex('1, 1'b0);
    applyStimulus(1'b1, lng, 0, 0);
    checkOutput("allones_direct", NL'(comp1), NL'(lng[NL-1 -: NS]));

    $display("[TB] round trip");
    x0 = CWD'(randVec());
    x1 = CWD'(randVec());
    loadChunk(x0);
    loadChunk(x1);
    setIndex(randIndex(NS), 1'b0);
    applyStimulus(1'b0, '0, 0, 0);
    applyStimulus(1'b1, mExp, 0, 0);
    checkOutput("roundtrip1", NL'(comp1), NL'({x0, x1}));
    checkOutput("roundtrip3", NL'(comp3), NL'({x0, x1}));

    $display("[TB] ignored inputs while busy");
    applyStimulus(1'b0, '0, 10, 0);
    applyStimulus(1'b1, randVec(), 0, 0);

    $display("[TB] index_valid and start together");
    setIndex(randIndex(NS - 6), 1'b1);
    applyStimulus(1'b1, randVec(), 0, 0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, '0, 0, 100);
    loadChunk(CWD'(randVec()));
    loadChunk(CWD'(randVec()));
    setIndex(randIndex(NS), 1'b0);
    applyStimulus(1'b0, '0, 0, 0);

    $display("[TB] random operations");
    for (int r = 0; r < 4; r++) begin
      if ($urandom_range(1, 0) == 1) loadChunk(CWD'(randVec()));
      setIndex(randIndex(NS - 3 + int'($urandom_range(6, 0))), 1'b0);
      applyStimulus(1'($urandom_range(1, 0)), randVec(), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
